usb_tx_line_encoder: RTL and testbench

Serial back end of the USB transmitter, directly downstream of the byte parallel-to-serial register. Owns bit timing for the transmitter.
- Strobes the byte register to shift out one bit per USB bit period.
- Inserts a stuff bit after six consecutive ones and NRZI-encodes the result onto d_plus/d_minus.
- Generates the EOP: SE0 for 2 bits, then J for 1 bit.
- Tells the transmit FSM when each byte has been consumed.

---
 rtl/usb_tx_pkg.sv | 23 ++
 rtl/usb_bit_timer.sv | 32 +++
 rtl/usb_tx_line_encoder.sv | 132 +++++++++++++
 tb/tb_usb_tx_line_encoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit line encoder.
// Line levels are expressed as {d_plus, d_minus}.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    EOP_SE0 = 2'd2,
    EOP_J   = 2'd3
  } tx_enc_state_t;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int STUFF_LIMIT = 6;

  // NRZI: a transition on the line encodes a zero (or a stuff bit).
  function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
    return ~line;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Rollover counter that marks the last clock of every USB bit period.
// Held at zero while cleared, so the first period after a clear is full length.
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic boundary
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign boundary = en && (cnt == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= boundary ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// Serial back end of the USB transmitter: bit timing, bit stuffing, NRZI
// encoding onto D+/D-, and EOP generation (SE0 x2 then J).
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tx_start,
  input  logic serial_in,
  input  logic eop_req,
  output logic shift_strobe,
  output logic byte_done,
  output logic d_plus,
  output logic d_minus,
  output logic tx_busy,
  output logic eop_done
);

  tx_enc_state_t state;
  logic [1:0]    line;
  logic [2:0]    ones_cnt;
  logic [2:0]    bit_cnt;
  logic          eop_pending;
  logic          se0_second;

  logic          timer_en;
  logic          timer_clr;
  logic          bit_end;
  logic          stuff_due;
  logic          data_shift;

  assign timer_en  = (state != IDLE);
  assign timer_clr = (state == IDLE);

  usb_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (timer_en),
    .clr      (timer_clr),
    .boundary (bit_end)
  );

  assign stuff_due  = (ones_cnt == 3'(STUFF_LIMIT));
  assign data_shift = (state == DATA) && bit_end && !stuff_due && !eop_pending;

  // Strobes are decoded from registered state so the byte register shifts
  // and reloads on the same edge that consumes its current bit.
  assign shift_strobe = data_shift;
  assign byte_done    = data_shift && (bit_cnt == 3'd7);
  assign eop_done     = (state == EOP_J) && bit_end;

  assign {d_plus, d_minus} = line;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      line        <= LINE_J;
      ones_cnt    <= '0;
      bit_cnt     <= '0;
      eop_pending <= 1'b0;
      se0_second  <= 1'b0;
      tx_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          line <= LINE_J;
          if (tx_start) begin
            state       <= DATA;
            ones_cnt    <= '0;
            bit_cnt     <= '0;
            eop_pending <= 1'b0;
            se0_second  <= 1'b0;
            tx_busy     <= 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (stuff_due) begin
              line     <= nrzi_toggle(line);
              ones_cnt <= '0;
            end else if (eop_pending) begin
              state      <= EOP_SE0;
              line       <= LINE_SE0;
              se0_second <= 1'b0;
            end else begin
              if (serial_in) begin
                ones_cnt <= ones_cnt + 3'd1;
              end else begin
                line     <= nrzi_toggle(line);
                ones_cnt <= '0;
              end
              bit_cnt <= bit_cnt + 3'd1;
              if ((bit_cnt == 3'd7) && eop_req) begin
                eop_pending <= 1'b1;
              end
            end
          end
        end

        EOP_SE0: begin
          if (bit_end) begin
            if (se0_second) begin
              state <= EOP_J;
              line  <= LINE_J;
            end else begin
              se0_second <= 1'b1;
            end
          end
        end

        EOP_J: begin
          if (bit_end) begin
            state       <= IDLE;
            tx_busy     <= 1'b0;
            eop_pending <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          line  <= LINE_J;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder: a small byte-register model feeds
// serial_in, per-cycle traces are captured and compared to hand-derived values.
module tb_usb_tx_line_encoder;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic tx_start = 1'b0;
  logic serial_in;
  logic eop_req;
  logic shift_strobe, byte_done, d_plus, d_minus, tx_busy, eop_done;

  int checks = 0;
  int failures = 0;

  // Upstream byte register and transmit-FSM model.
  logic [7:0] pkt [0:3];
  int         nbytes = 1;
  logic       eop_en = 1'b0;
  int         idx = 0;
  logic [7:0] sreg = 8'h00;

  // Per-cycle trace; index k = k-th falling edge after the tx_start edge.
  logic [1:0] ln_tr   [0:MAXC];
  logic       sb_tr   [0:MAXC];
  logic       bd_tr   [0:MAXC];
  logic       ed_tr   [0:MAXC];
  logic       busy_tr [0:MAXC];

  usb_tx_line_encoder #(.CLKS_PER_BIT(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_start     (tx_start),
    .serial_in    (serial_in),
    .eop_req      (eop_req),
    .shift_strobe (shift_strobe),
    .byte_done    (byte_done),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .tx_busy      (tx_busy),
    .eop_done     (eop_done)
  );

  always #5 clk = ~clk;

  assign serial_in = sreg[0];
  assign eop_req   = eop_en && (idx == nbytes - 1);

  always @(posedge clk) begin
    if (tx_start && !tx_busy) begin
      idx  <= 0;
      sreg <= pkt[0];
    end else if (byte_done) begin
      idx  <= idx + 1;
      sreg <= (idx < 3) ? pkt[idx + 1] : 8'h00;
    end else if (shift_strobe) begin
      sreg <= {1'b0, sreg[7:1]};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Records n cycles; tx_start (raised by the caller) drops after cycle 1
  // unless a re-pulse is requested at cycle pa or pb.
  task automatic capture(input int n, input int pa, input int pb);
    for (int k = 0; k <= MAXC; k++) begin
      ln_tr[k] = 2'bxx; sb_tr[k] = 1'b0; bd_tr[k] = 1'b0;
      ed_tr[k] = 1'b0;  busy_tr[k] = 1'b0;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      ln_tr[k]   = {d_plus, d_minus};
      sb_tr[k]   = shift_strobe;
      bd_tr[k]   = byte_done;
      ed_tr[k]   = eop_done;
      busy_tr[k] = tx_busy;
      tx_start   = (k == pa) || (k == pb);
    end
    tx_start = 1'b0;
  endtask

  task automatic start_pkt(input logic [7:0] b0, input logic [7:0] b1, input int n,
                           input logic en);
    pkt[0] = b0; pkt[1] = b1; pkt[2] = 8'h00; pkt[3] = 8'h00;
    nbytes = n;
    eop_en = en;
    tx_start = 1'b1;
  endtask

  function automatic int count_sb(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += int'(sb_tr[k]);
    return c;
  endfunction

  function automatic int count_sb_off_grid(input int hi);
    int c = 0;
    for (int k = 1; k <= hi; k++) if (sb_tr[k] && (k % 8 != 0)) c++;
    return c;
  endfunction

  function automatic int count_bd(input int hi);
    int c = 0;
    for (int k = 1; k <= hi; k++) c += int'(bd_tr[k]);
    return c;
  endfunction

  function automatic int count_ed(input int hi);
    int c = 0;
    for (int k = 1; k <= hi; k++) c += int'(ed_tr[k]);
    return c;
  endfunction

  function automatic int count_line(input int lo, input int hi, input logic [1:0] v);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (ln_tr[k] === v) c++;
    return c;
  endfunction

  function automatic int first_se0(input int hi);
    for (int k = 1; k <= hi; k++) if (ln_tr[k] === SE0) return k;
    return -1;
  endfunction

  function automatic int count_busy(input int hi);
    int c = 0;
    for (int k = 1; k <= hi; k++) c += int'(busy_tr[k]);
    return c;
  endfunction

  // Line level just after each of the first nb bit boundaries, first in the MSBs.
  function automatic logic [63:0] line_sig(input int nb);
    logic [63:0] r = '0;
    for (int j = 1; j <= nb; j++) r = (r << 2) | 64'(ln_tr[8 * j + 1]);
    return r;
  endfunction

  initial begin
    #200_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_lines", {d_plus, d_minus}, J);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_strobe", {shift_strobe, byte_done, eop_done}, 3'b000);
    n_rst = 1'b1;
    @(negedge clk);

    // SYNC pattern 0x80, no EOP.
    start_pkt(8'h80, 8'h00, 1, 1'b0);
    capture(70, -1, -1);
    check("sync_lines", line_sig(8), 64'h6665);
    check("sync_first_period_j", count_line(1, 8, J), 8);
    check("sync_strobes", count_sb(1, 70), 8);
    check("sync_strobe_spacing", count_sb_off_grid(70), 0);
    check("sync_byte_done_cnt", count_bd(70), 1);
    check("sync_byte_done_at64", bd_tr[64], 1'b1);

    // Asynchronous reset mid-packet: lines are K at this point.
    #2 n_rst = 1'b0;
    #1;
    check("midrst_lines", {d_plus, d_minus}, J);
    check("midrst_busy", tx_busy, 1'b0);
    check("midrst_strobe", {shift_strobe, byte_done, eop_done}, 3'b000);
    @(negedge clk);
    n_rst = 1'b1;
    capture(30, -1, -1);
    check("postrst_no_strobe", count_sb(1, 30), 0);
    check("postrst_idle_busy", count_busy(30), 0);
    check("postrst_lines_j", count_line(1, 30, J), 30);

    // Stuffing across 0xFF, 0x00 then EOP.
    start_pkt(8'hFF, 8'h00, 2, 1'b1);
    capture(180, -1, -1);
    check("stuff_lines", line_sig(18),
          64'(36'b10_10_10_10_10_10_01_01_01_10_01_10_01_10_01_10_01_00));
    check("stuff_strobes", count_sb(1, 144), 16);
    check("stuff_no_strobe_at_stuff", sb_tr[56], 1'b0);
    check("stuff_byte_done_pos", {bd_tr[72], bd_tr[136]}, 2'b11);
    check("stuff_byte_done_cnt", count_bd(180), 2);
    check("stuff_eop_done_at168", ed_tr[168], 1'b1);
    check("stuff_busy_fall", {busy_tr[168], busy_tr[169]}, 2'b10);

    // EOP after a single 0x00.
    @(negedge clk);
    start_pkt(8'h00, 8'h00, 1, 1'b1);
    capture(110, -1, -1);
    check("eop_lines", line_sig(9), 64'(18'b01_10_01_10_01_10_01_10_00));
    check("eop_se0_first", 64'(first_se0(110)), 64'(73));
    check("eop_se0_len", count_line(1, 110, SE0), 16);
    check("eop_j_after_se0", count_line(89, 96, J), 8);
    check("eop_done_cnt", count_ed(110), 1);
    check("eop_done_at96", ed_tr[96], 1'b1);
    check("eop_busy_fall", {busy_tr[96], busy_tr[97]}, 2'b10);

    // Stuff bit owed before EOP: 0xFC.
    @(negedge clk);
    start_pkt(8'hFC, 8'h00, 1, 1'b1);
    capture(120, -1, -1);
    check("stuffeop_lines", line_sig(10), 64'(20'b01_10_10_10_10_10_10_10_01_00));
    check("stuffeop_se0_first", 64'(first_se0(120)), 64'(81));
    check("stuffeop_no_strobe_at72", sb_tr[72], 1'b0);
    check("stuffeop_strobes", count_sb(1, 120), 8);
    check("stuffeop_eop_done_at104", ed_tr[104], 1'b1);

    // tx_start re-pulsed during DATA and during EOP_SE0 must be ignored.
    @(negedge clk);
    start_pkt(8'h00, 8'h00, 1, 1'b1);
    capture(110, 20, 78);
    check("ign_lines", line_sig(9), 64'(18'b01_10_01_10_01_10_01_10_00));
    check("ign_strobes", count_sb(1, 110), 8);
    check("ign_se0_first", 64'(first_se0(110)), 64'(73));
    check("ign_se0_len", count_line(1, 110, SE0), 16);
    check("ign_eop_done_at96", {ed_tr[96], 32'(count_ed(110))}, {1'b1, 32'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
